// File: rtl/fp16_pkg.sv
// Shared fp16 definitions for the CNN datapath: widths, constants,
// field view of a half-precision word and packed-bus slice helper.
package fp16_pkg;

    localparam int unsigned FP16_W    = 16;
    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

    // Low bit of requester idx's operand inside a packed NUM_REQ*16 bus.
    function automatic int unsigned fp16_slice_lo(input int unsigned idx);
        return idx * FP16_W;
    endfunction

endpackage

// File: rtl/fadd_share_arb_if.sv
// Request/response bundle between the requesters and the shared-adder arbiter.
interface fadd_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] opA;
    logic [NUM_REQ*DATA_W-1:0] opB;
    logic [NUM_REQ-1:0]        gnt;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_sum;
    logic                      busy;

    modport master (
        output req, opA, opB,
        input  gnt, rsp_valid, rsp_id, rsp_sum, busy
    );

    modport slave (
        input  req, opA, opB,
        output gnt, rsp_valid, rsp_id, rsp_sum, busy
    );
endinterface

// File: rtl/floatAdd.sv
// Combinational IEEE-754 half-precision adder, round-to-nearest-even,
// full subnormal support; NaN results are the canonical quiet NaN 7E00.
module floatAdd
    import fp16_pkg::*;
(
    input  logic [15:0] floatA,
    input  logic [15:0] floatB,
    output logic [15:0] sum
);

    fp16_t       a, b, big, sml;
    logic        swap, eff_sub, a_nan, b_nan, a_inf, b_inf, rnd_up;
    logic [4:0]  e_big, e_sml, d, lim, lz, sh;
    logic [10:0] m_big, m_sml, mant, mant_f;
    logic [27:0] sh_b;
    logic [13:0] a_al, b_al, norm;
    logic [14:0] raw;
    logic [5:0]  exp_n, exp_f;
    logic [11:0] mr;

    // Align the smaller operand (sticky jammed into LSB), add/sub, normalise, round.
    always_comb begin
        a       = floatA;
        b       = floatB;
        swap    = (b[14:0] > a[14:0]);
        big     = swap ? b : a;
        sml     = swap ? a : b;
        e_big   = (big.exp == 5'd0) ? 5'd1 : big.exp;
        e_sml   = (sml.exp == 5'd0) ? 5'd1 : sml.exp;
        m_big   = {big.exp != 5'd0, big.frac};
        m_sml   = {sml.exp != 5'd0, sml.frac};
        d       = e_big - e_sml;
        sh_b    = {m_sml, 17'b0} >> d;
        a_al    = {m_big, 3'b000};
        b_al    = {sh_b[27:15], sh_b[14] | (|sh_b[13:0])};
        eff_sub = a.sign ^ b.sign;
        raw     = eff_sub ? ({1'b0, a_al} - {1'b0, b_al}) : ({1'b0, a_al} + {1'b0, b_al});

        lz = 5'd14;
        for (int unsigned i = 0; i < 14; i++) begin
            if (raw[i]) lz = 5'(13 - i);
        end
        lim = e_big - 5'd1;
        sh  = (lz > lim) ? lim : lz;

        if (raw[14]) begin
            norm  = {raw[14:2], raw[1] | raw[0]};
            exp_n = {1'b0, e_big} + 6'd1;
        end else begin
            norm  = raw[13:0] << sh;
            exp_n = {1'b0, e_big} - {1'b0, sh};
        end

        mant   = norm[13:3];
        rnd_up = norm[2] & ((|norm[1:0]) | mant[0]);
        mr     = {1'b0, mant} + {11'b0, rnd_up};
        if (mr[11]) begin
            mant_f = mr[11:1];
            exp_f  = exp_n + 6'd1;
        end else begin
            mant_f = mr[10:0];
            exp_f  = exp_n;
        end

        a_nan = (a.exp == 5'h1F) && (a.frac != 10'd0);
        b_nan = (b.exp == 5'h1F) && (b.frac != 10'd0);
        a_inf = (a.exp == 5'h1F) && (a.frac == 10'd0);
        b_inf = (b.exp == 5'h1F) && (b.frac == 10'd0);

        if (a_nan || b_nan || (a_inf && b_inf && eff_sub))
            sum = 16'h7E00;
        else if (a_inf)
            sum = {a.sign, 15'h7C00};
        else if (b_inf)
            sum = {b.sign, 15'h7C00};
        else if (raw == 15'd0)
            sum = {a.sign & b.sign, 15'h0000};
        else if (exp_f >= 6'd31)
            sum = {big.sign, 15'h7C00};
        else
            sum = {big.sign, mant_f[10] ? exp_f[4:0] : 5'd0, mant_f[9:0]};
    end

endmodule

// File: rtl/fadd_share_arb.sv
// Round-robin arbiter sharing one fp16 adder among NUM_REQ requesters;
// the granted sum is registered and returned one cycle later with its ID.
module fadd_share_arb
    import fp16_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int DATA_W  = FP16_W
) (
    input logic           clk,
    input logic           rst,
    fadd_share_arb_if.slave bus
);

    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    cand, gnt_idx;
    logic               gnt_any;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [DATA_W-1:0]  a_sel, b_sel, sum_w;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [DATA_W-1:0]  rsp_sum_q;

    // Grant the first requester found scanning upward from just past the pointer.
    always_comb begin
        gnt_vec = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!gnt_any && bus.req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_vec[gnt_idx] = gnt_any;
    end

    // Operand mux; gnt_idx is 0 when idle, so the idle sum is simply ignored.
    always_comb begin
        a_sel = bus.opA[fp16_slice_lo(32'(gnt_idx)) +: DATA_W];
        b_sel = bus.opB[fp16_slice_lo(32'(gnt_idx)) +: DATA_W];
    end

    floatAdd u_fadd (
        .floatA (a_sel),
        .floatB (b_sel),
        .sum    (sum_w)
    );

    // Pointer advance and response capture; ID/sum hold across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= FP16_ZERO;
        end else begin
            rsp_valid_q <= gnt_any;
            if (gnt_any) begin
                ptr_q     <= gnt_idx;
                rsp_id_q  <= gnt_idx;
                rsp_sum_q <= sum_w;
            end
        end
    end

    assign bus.gnt       = gnt_vec;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.busy      = rsp_valid_q;

endmodule

// File: tb/tb_fadd_share_arb.sv
// Directed + randomised bench for fadd_share_arb: round-robin order from a
// "last winner" model, sums from exact real arithmetic rounded to fp16.
module tb_fadd_share_arb;

    localparam int N = 4;

    logic clk;
    logic rst;

    fadd_share_arb_if #(.NUM_REQ(N)) bus_if ();

    fadd_share_arb #(.NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          last   = N - 1;
    logic        exp_valid = 1'b0;
    logic [1:0]  exp_id    = '0;
    logic [15:0] exp_sum   = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic real pow2(input int k);
        real p = 1.0;
        if (k >= 0) repeat (k) p = p * 2.0;
        else        repeat (-k) p = p / 2.0;
        return p;
    endfunction

    function automatic real f2r(input logic [15:0] h);
        int  e = int'(h[14:10]);
        int  m = int'(h[9:0]);
        real v;
        if (e == 0) v = $itor(m) * pow2(-24);
        else        v = $itor(m + 1024) * pow2(e - 25);
        return h[15] ? -v : v;
    endfunction

    function automatic int rne(input real x);
        real fl = $floor(x);
        real fr = x - fl;
        int  q  = $rtoi(fl);
        if (fr > 0.5 || (fr == 0.5 && (q % 2) == 1)) q++;
        return q;
    endfunction

    // Exact real sum, then IEEE round-to-nearest-even into fp16.
    function automatic logic [15:0] fadd_model(input logic [15:0] x, input logic [15:0] y);
        real  r = f2r(x) + f2r(y);
        real  a, p;
        logic s;
        int   e, q;
        if (r == 0.0) return {x[15] & y[15], 15'h0000};
        s = (r < 0.0);
        a = s ? -r : r;
        if (a < pow2(-14)) begin
            q = rne(a * pow2(24));
            return {s, 15'(q)};
        end
        e = -14;
        p = pow2(-14);
        while (a >= 2.0 * p && e < 16) begin
            p = p * 2.0;
            e++;
        end
        q = rne(a / p * 1024.0);
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        if (e > 15) return {s, 15'h7C00};
        return {s, 5'(e + 15), 10'(q)};
    endfunction

    function automatic logic [15:0] rnd_fp16();
        logic [15:0] v;
        v[15]    = 1'($urandom_range(0, 1));
        v[14:10] = 5'($urandom_range(0, 30));
        v[9:0]   = 10'($urandom);
        return v;
    endfunction

    // Drive one cycle of requests (called in the low phase), check the
    // combinational grant, then check the registered response after the edge.
    task automatic step(input logic [3:0] r, input logic [63:0] a, input logic [63:0] b);
        int          gi = -1;
        logic [3:0]  eg;
        bus_if.req = r;
        bus_if.opA = a;
        bus_if.opB = b;
        #1;
        for (int k = 1; k <= N; k++) begin
            if (gi < 0 && r[(last + k) % N]) gi = (last + k) % N;
        end
        eg = (gi < 0) ? 4'b0000 : 4'(1 << gi);
        chk("gnt", 32'(bus_if.gnt), 32'(eg));
        @(posedge clk);
        #1;
        if (gi >= 0) begin
            exp_valid = 1'b1;
            exp_id    = 2'(gi);
            exp_sum   = fadd_model(a[gi*16 +: 16], b[gi*16 +: 16]);
            last      = gi;
        end else begin
            exp_valid = 1'b0;
        end
        chk("rsp_valid", 32'(bus_if.rsp_valid), 32'(exp_valid));
        chk("busy",      32'(bus_if.busy),      32'(exp_valid));
        chk("rsp_id",    32'(bus_if.rsp_id),    32'(exp_id));
        chk("rsp_sum",   32'(bus_if.rsp_sum),   32'(exp_sum));
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("rst_busy",  32'(bus_if.busy),      32'd0);
        chk("rst_id",    32'(bus_if.rsp_id),    32'd0);
        chk("rst_sum",   32'(bus_if.rsp_sum),   32'h0000);
        last      = N - 1;
        exp_valid = 1'b0;
        exp_id    = '0;
        exp_sum   = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] va, vb;
        logic [15:0] x, y;
        logic [3:0]  r;

        rst        = 1'b0;
        bus_if.req = '0;
        bus_if.opA = '0;
        bus_if.opB = '0;
        do_reset();

        // Idle after reset.
        for (int i = 0; i < 5; i++) step(4'b0000, 64'd0, 64'd0);

        // Single requester: 1.0 + 1.0.
        va = {16'h1111, 16'h2222, 16'h3C00, 16'h4444};
        vb = {16'h5555, 16'h6666, 16'h3C00, 16'h7777};
        step(4'b0010, va, vb);
        chk("single_id",  32'(bus_if.rsp_id),  32'd1);
        chk("single_sum", 32'(bus_if.rsp_sum), 32'h4000);

        // All four requesting continuously: 0.5 + 0.25 each, strict rotation.
        do_reset();
        va = {4{16'h3800}};
        vb = {4{16'h3400}};
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, va, vb);
            chk("rr_id",  32'(bus_if.rsp_id),  32'(i % N));
            chk("rr_sum", 32'(bus_if.rsp_sum), 32'h3A00);
        end

        // Wrap and skip: pointer parked on 2, then requesters 0 and 2.
        va = {16'h0000, 16'h39D2, 16'h0000, 16'hC000};
        vb = {16'h0000, 16'h0000, 16'h0000, 16'h3C00};
        step(4'b0100, va, vb);
        step(4'b0101, va, vb);
        chk("wrap_id",  32'(bus_if.rsp_id),  32'd0);
        chk("wrap_sum", 32'(bus_if.rsp_sum), 32'hBC00);
        step(4'b0101, va, vb);
        chk("skip_id",  32'(bus_if.rsp_id),  32'd2);
        chk("skip_sum", 32'(bus_if.rsp_sum), 32'h39D2);

        // Reset mid-stream with a response pending and all requests high.
        va = {4{16'h3800}};
        vb = {4{16'h3400}};
        step(4'b1111, va, vb);
        step(4'b1111, va, vb);
        chk("pre_rst_valid", 32'(bus_if.rsp_valid), 32'd1);
        do_reset();
        step(4'b1111, va, vb);
        chk("post_rst_id", 32'(bus_if.rsp_id), 32'd0);

        // Randomised traffic with cancellations, equal operands and overflow.
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < N; j++) begin
                x = rnd_fp16();
                case ($urandom_range(0, 5))
                    0:       y = x ^ 16'h8000;
                    1:       y = x;
                    2:       y = {~x[15], x[14:10], 10'($urandom)};
                    default: y = rnd_fp16();
                endcase
                va[j*16 +: 16] = x;
                vb[j*16 +: 16] = y;
            end
            r = 4'($urandom_range(0, 15));
            step(r, va, vb);
        end
        step(4'b0000, 64'd0, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fadd_share_arb.md
Name: fadd_share_arb

Overview:
- Round-robin arbiter that shares one combinational fp16 adder (floatAdd) among NUM_REQ requesters in the CNN datapath. Example requesters: partial-sum accumulators and bias adders.
- Each cycle it grants at most one requester and feeds that requester's operand pair to floatAdd.
- The sum is registered and returned one cycle later, tagged with the requester ID.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of requester ID tag.
- DATA_W, 16, IEEE-754 half-precision operand width (fixed at 16; parameter is for readability only).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; bit i high means requester i has valid operands.
- opA  input  NUM_REQ*DATA_W  packed operand A; requester i uses bits [i*16 +: 16].
- opB  input  NUM_REQ*DATA_W  packed operand B, same packing.
- gnt  output  NUM_REQ  one-hot grant (combinational, same cycle as req).
- rsp_valid  output  1  registered; result available this cycle.
- rsp_id  output  ID_W  registered; index of the requester whose sum is on rsp_sum.
- rsp_sum  output  DATA_W  registered fp16 sum from floatAdd.
- busy  output  1  registered; high if any grant was issued in the previous cycle (equals rsp_valid; kept for the status CSR).

Behaviour:
- Reset (async, rst=1): rsp_valid=0, rsp_id=0, rsp_sum=16'h0000, busy=0, priority pointer ptr=NUM_REQ-1, so requester 0 has top priority after reset.
- gnt is a pure function of req and ptr; no latch or registered state on gnt.
- Arbitration: scan i = ptr+1, ptr+2, ... modulo NUM_REQ; grant the first i with req[i]=1.
  - gnt is one-hot, or all-zero when req is all-zero.
  - Index wrap past NUM_REQ-1 returns to 0.
- Pointer update: on a clock edge with any gnt bit set, ptr <= granted index. If no grant, ptr holds.
- Datapath mux:
  - floatAdd.floatA = opA slice of the granted index; floatAdd.floatB = opB slice of the granted index.
  - With no grant the mux selects index 0. The sum is ignored.
- Response register, on every edge:
  - rsp_valid <= |gnt.
  - When a grant exists: rsp_id <= granted index, rsp_sum <= floatAdd.sum.
  - With no grant, rsp_id and rsp_sum hold their previous values.
- Latency: exactly 1 cycle from grant to rsp_valid. Throughput: 1 addition per cycle total.
- Handshake:
  - A requester holds req high and its operands stable until it sees its gnt bit high at a clock edge.
  - It may drop req, or present new operands, in the cycle after the grant.
  - If req stays high with new operands, it is a new request and re-enters arbitration behind the others.
- Fairness: a continuously asserting requester is granted at least once every NUM_REQ cycles. No starvation.
- Simultaneous events:
  - Any set of req bits may rise in the same cycle; exactly one is granted.
  - A requester dropping req before its grant is legal and simply withdraws the request.
- Reset mid-operation: a pending response is discarded. rsp_valid is 0 immediately (async). The next grant after reset release favours requester 0.
- Arithmetic: sum rounding, zero, subnormal and sign handling are those of floatAdd. The arbiter does no arithmetic and does not modify operand bits.

Decomposition:
- Shared package fp16_pkg:
  - FP16_W=16.
  - FP16_ZERO=16'h0000, FP16_ONE=16'h3C00.
  - Helper function for the packed-slice index.
- Sub-module: floatAdd (existing combinational adder), instantiated once as u_fadd.
- A separate rr_arbiter sub-module is optional. The grant logic is small enough to stay inline.

Test Plan:
- Reset then idle: rst pulse, req=0 for 5 cycles -> gnt=0, rsp_valid=0, rsp_sum=0000 throughout.
- Single requester:
  - Stimulus: req=4'b0010, opA[1]=3C00 (1.0), opB[1]=3C00.
  - Response: gnt=0010 same cycle. Next cycle rsp_valid=1, rsp_id=1, rsp_sum=4000 (2.0).
- All four requesting continuously:
  - Stimulus, after reset: requester i has opA=3800 (0.5), opB=3400 (0.25).
  - Response: grants cycle 0001, 0010, 0100, 1000, 0001... Each rsp_sum=3A00 (0.75), rsp_id=0,1,2,3,0.
- Wrap and skip:
  - Stimulus: ptr at 2 (last grant to requester 2), then req=4'b0101.
  - Response: gnt=0001 (wraps past 3). Next cycle req still 0101 -> gnt=0100.
  - Sums: requester 0 has C000+3C00 -> rsp_sum=BC00 (-1.0). Requester 2 has 39D2+0000 -> rsp_sum=39D2.
- Reset mid-stream:
  - Stimulus: assert rst asynchronously between edges while rsp_valid=1 and all req high.
  - Response: rsp_valid drops immediately. After release the first grant is 0001.
